// File: rtl/p_hardisc.sv
// Shared constants and helpers for the hardisc front end.
package p_hardisc;

    // Default number of 32-bit entries in the instruction fetch buffer.
    localparam int IFB_DEPTH = 4;

    // Fetch status codes carried alongside each fetched word.
    localparam logic [2:0] FETCH_VALID = 3'b000;
    localparam logic [2:0] FETCH_INCOM = 3'b001;
    localparam logic [2:0] FETCH_BSERR = 3'b010;
    localparam logic [2:0] FETCH_UCERR = 3'b011;

    // Per-entry side information stored next to the fetched word.
    typedef struct packed {
        logic [2:0] ferr;
        logic       lpinv;
    } ifb_meta_t;

    // Packs the aligner-facing info vector {ferr, lpinv, nop}.
    function automatic logic [4:0] ifb_info(input logic [2:0] ferr, input logic lpinv, input logic nop);
        return {ferr, lpinv, nop};
    endfunction

endpackage

// File: rtl/ifb_chk.sv
// Protocol checker for ifb: the fetch side must not offer a word while the
// buffer is full and the head is not being consumed.
module ifb_chk (
    input logic clk,
    input logic rst,
    input logic en,
    input logic wr_valid,
    input logic full,
    input logic stall,
    input logic flush
);

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (rst || !en)
        !(wr_valid && full && stall && !flush)
    ) else $error("ifb: write offered while buffer full");

endmodule

// File: rtl/seu_ff.sv
// Payload register with write enable; instances are labelled so the
// fault-injection flow can locate them. Contents are intentionally unreset.
module seu_ff #(
    parameter int    LEN   = 1,
    parameter string LABEL = "SEU"
) (
    input  logic           s_c_i,
    input  logic           s_we_i,
    input  logic [LEN-1:0] s_d_i,
    output logic [LEN-1:0] s_q_o
);

    logic [LEN-1:0] q_r;

    // Capture new data only when written.
    always_ff @(posedge s_c_i) begin
        if (s_we_i) begin
            q_r <= s_d_i;
        end
    end

    assign s_q_o = q_r;

    // The label only tags the instance; an unnamed instance gets no extra logic.
    if (LABEL == "") begin : g_unlabelled
    end

endmodule

// File: rtl/ifb.sv
// Instruction fetch buffer: circular queue of fetched 32-bit words with
// their status bits, presented head-first to the instruction aligner.
module ifb #(
    parameter int IFB_DEPTH = p_hardisc::IFB_DEPTH
) (
    input  logic        s_clk_i,
    input  logic        s_reset_i,
    input  logic        s_flush_i,
    input  logic        s_wr_valid_i,
    input  logic [31:0] s_wr_instr_i,
    input  logic [2:0]  s_wr_ferr_i,
    input  logic        s_wr_lpinv_i,
    input  logic [1:0]  s_wr_pred_i,
    output logic        s_full_o,
    output logic        s_afull_o,
    input  logic        s_stall_i,
    output logic [4:0]  s_info_o,
    output logic [31:0] s_instr_o,
    output logic [1:0]  s_pred_o
);

    localparam int             PW      = $clog2(IFB_DEPTH);
    localparam logic [PW-1:0]  PTR_ONE = PW'(1);
    localparam logic [PW:0]    CNT_ONE = (PW+1)'(1);
    localparam logic [PW:0]    CNT_MAX = (PW+1)'(IFB_DEPTH);
    localparam logic [PW:0]    CNT_AFL = (PW+1)'(IFB_DEPTH - 1);

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;

    logic          full_s;
    logic          nonempty_s;
    logic          push_s;
    logic          pop_s;

    logic [31:0]           instr_q_s [IFB_DEPTH];
    p_hardisc::ifb_meta_t  meta_q_s  [IFB_DEPTH];
    logic [1:0]            pred_q_s  [IFB_DEPTH];

    assign full_s     = (count_r == CNT_MAX);
    assign nonempty_s = (count_r != {(PW+1){1'b0}});
    // A pop in the same cycle frees the slot, so a full buffer can still accept.
    assign pop_s      = nonempty_s & ~s_stall_i & ~s_flush_i;
    assign push_s     = s_wr_valid_i & ~s_flush_i & (~full_s | pop_s);

    assign s_full_o   = full_s;
    assign s_afull_o  = (count_r >= CNT_AFL);

    // Pointer and occupancy tracking; flush clears everything at the next edge.
    always_ff @(posedge s_clk_i or posedge s_reset_i) begin
        if (s_reset_i) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else if (s_flush_i) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Payload storage, one labelled register set per slot.
    for (genvar i = 0; i < IFB_DEPTH; i++) begin : g_slot
        logic we_s;
        assign we_s = push_s & (wr_ptr_r == PW'(i));

        seu_ff #(.LEN(32), .LABEL("IFB_INSTR")) u_instr (
            .s_c_i  (s_clk_i),
            .s_we_i (we_s),
            .s_d_i  (s_wr_instr_i),
            .s_q_o  (instr_q_s[i])
        );

        seu_ff #(.LEN(4), .LABEL("IFB_INFO")) u_info (
            .s_c_i  (s_clk_i),
            .s_we_i (we_s),
            .s_d_i  ({s_wr_ferr_i, s_wr_lpinv_i}),
            .s_q_o  (meta_q_s[i])
        );

        seu_ff #(.LEN(2), .LABEL("IFB_PRED")) u_pred (
            .s_c_i  (s_clk_i),
            .s_we_i (we_s),
            .s_d_i  (s_wr_pred_i),
            .s_q_o  (pred_q_s[i])
        );
    end

    // Present the head entry, or the empty pattern when nothing is stored.
    always_comb begin
        s_info_o  = p_hardisc::ifb_info(3'b000, 1'b0, 1'b1);
        s_instr_o = 32'h0000_0000;
        s_pred_o  = 2'b00;
        if (nonempty_s) begin
            s_info_o  = p_hardisc::ifb_info(meta_q_s[rd_ptr_r].ferr, meta_q_s[rd_ptr_r].lpinv, 1'b0);
            s_instr_o = instr_q_s[rd_ptr_r];
            s_pred_o  = pred_q_s[rd_ptr_r];
        end else begin
            s_info_o  = p_hardisc::ifb_info(3'b000, 1'b0, 1'b1);
            s_instr_o = 32'h0000_0000;
            s_pred_o  = 2'b00;
        end
    end

endmodule

// File: tb/tb_ifb.sv
// Self-checking bench for ifb: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_ifb;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        wr_valid;
    logic [31:0] wr_instr;
    logic [2:0]  wr_ferr;
    logic        wr_lpinv;
    logic [1:0]  wr_pred;
    logic        full;
    logic        afull;
    logic        stall;
    logic [4:0]  info;
    logic [31:0] instr;
    logic [1:0]  pred;
    logic        chk_en;

    int cmp_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  ferr;
        logic        lpinv;
        logic [1:0]  pred;
    } ent_t;

    ent_t mq[$];

    ifb #(.IFB_DEPTH(DEPTH)) dut (
        .s_clk_i      (clk),
        .s_reset_i    (rst),
        .s_flush_i    (flush),
        .s_wr_valid_i (wr_valid),
        .s_wr_instr_i (wr_instr),
        .s_wr_ferr_i  (wr_ferr),
        .s_wr_lpinv_i (wr_lpinv),
        .s_wr_pred_i  (wr_pred),
        .s_full_o     (full),
        .s_afull_o    (afull),
        .s_stall_i    (stall),
        .s_info_o     (info),
        .s_instr_o    (instr),
        .s_pred_o     (pred)
    );

    ifb_chk u_chk (
        .clk      (clk),
        .rst      (rst),
        .en       (chk_en),
        .wr_valid (wr_valid),
        .full     (full),
        .stall    (stall),
        .flush    (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare all outputs against what the model says the head looks like.
    task automatic check_model();
        if (mq.size() == 0) begin
            chk("info", {27'd0, info}, 32'h0000_0001);
            chk("instr", instr, 32'h0000_0000);
            chk("pred", {30'd0, pred}, 32'h0000_0000);
        end else begin
            chk("info", {27'd0, info}, {27'd0, mq[0].ferr, mq[0].lpinv, 1'b0});
            chk("instr", instr, mq[0].instr);
            chk("pred", {30'd0, pred}, {30'd0, mq[0].pred});
        end
        chk("full", {31'd0, full}, {31'd0, (mq.size() == DEPTH)});
        chk("afull", {31'd0, afull}, {31'd0, (mq.size() >= DEPTH - 1)});
    endtask

    // One clock cycle: drive, check current state, take the edge, update model.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [2:0] fe,
                         input logic lp, input logic [1:0] pr, input logic st, input logic fl);
        bit do_pop;
        bit do_push;
        ent_t e;
        wr_valid = v;
        wr_instr = ins;
        wr_ferr  = fe;
        wr_lpinv = lp;
        wr_pred  = pr;
        stall    = st;
        flush    = fl;
        #4;
        check_model();
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            do_pop  = (mq.size() != 0) && !st;
            do_push = v && ((mq.size() < DEPTH) || do_pop);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e.instr = ins; e.ferr = fe; e.lpinv = lp; e.pred = pr;
                mq.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle(input logic st);
        cycle(1'b0, 32'h0, 3'b000, 1'b0, 2'b00, st, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_instr = 32'h0;
        wr_ferr = 3'b000; wr_lpinv = 1'b0; wr_pred = 2'b00; stall = 1'b0;
        chk_en = 1'b1;
        #16;
        check_model();
        rst = 1'b0;

        // Single push shows up on the next cycle.
        cycle(1'b1, 32'h00A3_0023, p_hardisc::FETCH_VALID, 1'b0, 2'b00, 1'b1, 1'b0);
        chk("r33_info", {27'd0, info}, 32'h0000_0000);
        chk("r33_instr", instr, 32'h00A3_0023);
        idle(1'b0);
        idle(1'b0);

        // Fill while stalled; an extra write while full is dropped.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 32'h1000_0000 + i, 3'(i), i[0], 2'(i), 1'b1, 1'b0);
        end
        chk("r34_full", {31'd0, full}, 32'h0000_0001);
        chk_en = 1'b0;
        cycle(1'b1, 32'hDEAD_BEEF, 3'b111, 1'b1, 2'b11, 1'b1, 1'b0);
        chk_en = 1'b1;
        chk("r34_head", instr, 32'h1000_0000);

        // Full with push and pop together keeps the buffer full and in order.
        cycle(1'b1, 32'h2000_0005, 3'b001, 1'b1, 2'b01, 1'b0, 1'b0);
        chk("r35_full", {31'd0, full}, 32'h0000_0001);
        chk("r35_head", instr, 32'h1000_0001);
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b0);

        // Flush with a concurrent push leaves the buffer empty.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h3000_0000 + i, 3'b000, 1'b0, 2'b00, 1'b1, 1'b0);
        cycle(1'b1, 32'h3333_3333, 3'b000, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("r36_info", {27'd0, info}, 32'h0000_0001);
        chk("r36_afull", {31'd0, afull}, 32'h0000_0000);

        // Side bits travel unmodified.
        cycle(1'b1, 32'h4444_0001, 3'b010, 1'b1, 2'b10, 1'b1, 1'b0);
        chk("r37_info", {27'd0, info}, 32'h0000_000A);
        chk("r37_pred", {30'd0, pred}, 32'h0000_0002);

        // Reset pulse between edges empties the outputs immediately.
        cycle(1'b1, 32'h5555_0001, 3'b000, 1'b0, 2'b01, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        mq.delete();
        chk("r38_info", {27'd0, info}, 32'h0000_0001);
        chk("r38_instr", instr, 32'h0000_0000);
        chk("r38_full", {31'd0, full}, 32'h0000_0000);
        rst = 1'b0;
        #1;
        cycle(1'b1, 32'h6666_0001, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("r30_head", instr, 32'h6666_0001);
        idle(1'b0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic v, st, fl;
            st = ($urandom_range(0, 99) < 35);
            fl = ($urandom_range(0, 99) < 4);
            v  = ($urandom_range(0, 99) < 65);
            if (mq.size() == DEPTH && st) v = 1'b0;
            cycle(v, $urandom, 3'($urandom), 1'($urandom), 2'($urandom), st, fl);
        end
        idle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
